cvxif_copro_sequencer: RTL and testbench
========================================

# cvxif_copro_sequencer

Issue/commit/result sequencer for the CV-X-IF example coprocessor. It decodes offloaded instructions against the four custom opcodes and holds accepted instructions in an in-order tracking buffer until the core commits or kills them. It then returns results to the core on the result channel in issue order. It sits between the CVA6 CV-X-IF master ports and the coprocessor datapath, and owns all handshake sequencing for that datapath.

## Interface
Parameters:
- XLEN, 32: register operand/result width.
- IdWidth, 3: width of the CV-X-IF instruction id.
- Depth, 4: tracking buffer entries; power of two, ≥2.

Ports:
- clk_i  in  1  single clock; all state on rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- issue_valid_i  in  1  issue request valid.
- issue_ready_o  out  1  issue request taken.
- issue_instr_i  in  32  offloaded instruction word.
- issue_id_i  in  IdWidth  instruction id.
- issue_rs1_i, issue_rs2_i  in  XLEN  source operands, valid with issue_valid_i.
- issue_accept_o  out  1  response: instruction accepted; valid while issue_valid_i && issue_ready_o.
- issue_writeback_o  out  1  response: instruction will write rd.
- commit_valid_i  in  1  commit/kill event.
- commit_id_i  in  IdWidth  id being committed.
- commit_kill_i  in  1  1 = kill, 0 = commit.
- result_valid_o  out  1  result valid.
- result_ready_i  in  1  core accepts result.
- result_id_o  out  IdWidth  id of result.
- result_we_o  out  1  register write enable.
- result_rd_o  out  5  destination register, instr[11:7].
- result_data_o  out  XLEN  result value.

## Operation
- Decode uses opcode instr[6:0] only. 0001011 gives accept=1, writeback=1, op ADD (rs1+rs2). 0101011 gives accept=1, writeback=0, op NOP (data 0). 1011011 gives accept=1, writeback=1, op XOR (rs1^rs2). 1111011 gives accept=1, writeback=1, op SUB (rs1-rs2). Any other opcode gives accept=0, writeback=0.
- Arithmetic wraps modulo 2^XLEN. Result data is computed and stored at issue.
- issue_ready_o = !full, where full means the entry count equals Depth. This applies even to instructions that would be rejected.
- Handshake (valid && ready) with accept=1 allocates the tail entry: {valid, id, we, rd, data, committed=0, killed=0}. Rejected instructions allocate nothing.
- Commit: commit_valid_i marks every valid entry whose id equals commit_id_i. It sets committed=1, and also sets killed=1 when commit_kill_i=1.
- A commit in the same cycle as an issue handshake with the same id also applies to the entry being allocated.
- A commit matching no entry is ignored.
- Head retirement runs each cycle:
  - Head valid && committed && killed: pop silently, no result.
  - Head valid && committed && !killed: drive result_valid_o=1 with the head fields.
  - Pop on result_valid_o && result_ready_i.
- At most one pop per cycle. Allocation and pop may occur in the same cycle; the count is unchanged and a full buffer stays full, so ready stays low that cycle.
- Results are always returned in issue order. A younger committed entry waits behind an uncommitted head.
- Head/tail pointers wrap modulo Depth. The count has log2(Depth)+1 bits.

## Timing
- Issue response is combinational in the handshake cycle.
- The commit/result path without the macro has the following latency:
  - Commit registered in cycle N gives result_valid_o in cycle N+1 if the entry is the head.
  - A killed head pops in cycle N+1 with no result.
- Throughput is one result per cycle when result_ready_i=1.
- result_valid_o stays high, and result_* stay stable, until result_ready_i.
- Reset state: all entries invalid, pointers and count 0. Outputs: issue_ready_o=1, result_valid_o=0, result_id_o=0, result_we_o=0, result_rd_o=0, result_data_o=0.
- Assertion of rst_ni mid-operation discards all entries immediately, including a pending unacknowledged result.

## Configuration
- CVXIF_SEQ_RESULT_REG_EN:
  - Defined: a pipeline register is inserted on the result channel, so the result reaches the outputs one cycle later (commit at N gives result_valid_o at N+2).
  - The register loads when empty or when its held result is accepted.
  - Full throughput is preserved, and result_* come directly from flops.
- Undefined: result_* are driven from the head entry, as described in Operation and Timing.

## Test plan
- Reset, then issue instr=0x0000008B (custom0, rd=1), id=2, rs1=5, rs2=7; commit id=2 kill=0 -> accept=1, writeback=1; result id=2, we=1, rd=1, data=12 one cycle after commit.
- Issue opcode 0110011 -> accept=0, writeback=0; no allocation; count stays 0; no result ever.
- Issue ids 0,1,2,3 (Depth=4) -> issue_ready_o=0 after the 4th. Commit id 0 with result_ready_i=1 -> ready returns to 1 the cycle after the pop.
- Issue id 0 then id 1; commit 1 first, then 0 three cycles later -> no result before commit 0; results id 0 then id 1 on consecutive cycles.
- Issue id 0 and id 1; kill id 0, commit id 1 -> only id 1 result returned, one cycle after both are committed. Custom1 (0101011) -> result we=0, data=0.
- Hold result_ready_i=0 for 5 cycles with a valid result, then pulse rst_ni low -> result stable during the stall, then result_valid_o=0 and issue_ready_o=1 immediately on reset assertion.

Source files
------------

// File: rtl/cvxif_copro_sequencer.sv
// CV-X-IF coprocessor issue/commit/result sequencer with an in-order tracking buffer.
// Optional macro CVXIF_SEQ_RESULT_REG_EN adds an output register on the result channel.
module cvxif_copro_sequencer #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned IdWidth = 3,
  parameter int unsigned Depth   = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [XLEN-1:0]    issue_rs1_i,
  input  logic [XLEN-1:0]    issue_rs2_i,
  output logic               issue_accept_o,
  output logic               issue_writeback_o,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic               result_we_o,
  output logic [4:0]         result_rd_o,
  output logic [XLEN-1:0]    result_data_o
);

  localparam int unsigned PW = $clog2(Depth);

  typedef enum logic [1:0] {OP_NOP, OP_ADD, OP_XOR, OP_SUB} op_e;

  logic               r_valid     [Depth];
  logic [IdWidth-1:0] r_id        [Depth];
  logic               r_we        [Depth];
  logic [4:0]         r_rd        [Depth];
  logic [XLEN-1:0]    r_data      [Depth];
  logic               r_committed [Depth];
  logic               r_killed    [Depth];
  logic [PW-1:0]      r_head, r_tail;
  logic [PW:0]        r_count;

  op_e             w_op;
  logic            w_acc, w_wb, w_full, w_alloc, w_same_commit;
  logic [XLEN-1:0] w_data;
  logic            w_head_res, w_head_kill, w_pop;
  logic            w_unused;

  assign w_unused = ^issue_instr_i[31:12];

  always_comb begin
    w_acc = 1'b0;
    w_wb  = 1'b0;
    w_op  = OP_NOP;
    unique case (issue_instr_i[6:0])
      7'b0001011: begin w_acc = 1'b1; w_wb = 1'b1; w_op = OP_ADD; end
      7'b0101011: begin w_acc = 1'b1; w_wb = 1'b0; w_op = OP_NOP; end
      7'b1011011: begin w_acc = 1'b1; w_wb = 1'b1; w_op = OP_XOR; end
      7'b1111011: begin w_acc = 1'b1; w_wb = 1'b1; w_op = OP_SUB; end
      default: ;
    endcase
  end

  always_comb begin
    w_data = '0;
    unique case (w_op)
      OP_ADD:  w_data = issue_rs1_i + issue_rs2_i;
      OP_XOR:  w_data = issue_rs1_i ^ issue_rs2_i;
      OP_SUB:  w_data = issue_rs1_i - issue_rs2_i;
      default: w_data = '0;
    endcase
  end

  assign w_full            = (r_count == (PW+1)'(Depth));
  assign issue_ready_o     = !w_full;
  assign issue_accept_o    = issue_valid_i && issue_ready_o && w_acc;
  assign issue_writeback_o = issue_valid_i && issue_ready_o && w_wb;
  assign w_alloc           = issue_valid_i && issue_ready_o && w_acc;
  assign w_same_commit     = commit_valid_i && (commit_id_i == issue_id_i);

  assign w_head_res  = r_valid[r_head] && r_committed[r_head] && !r_killed[r_head];
  assign w_head_kill = r_valid[r_head] && r_committed[r_head] &&  r_killed[r_head];

`ifdef CVXIF_SEQ_RESULT_REG_EN
  logic               r_res_valid;
  logic [IdWidth-1:0] r_res_id;
  logic               r_res_we;
  logic [4:0]         r_res_rd;
  logic [XLEN-1:0]    r_res_data;
  logic               w_load, w_take;

  assign w_load = !r_res_valid || result_ready_i;
  assign w_take = w_head_res && w_load;
  assign w_pop  = w_head_kill || w_take;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_we    <= 1'b0;
      r_res_rd    <= '0;
      r_res_data  <= '0;
    end else if (w_load) begin
      r_res_valid <= w_head_res;
      if (w_head_res) begin
        r_res_id   <= r_id[r_head];
        r_res_we   <= r_we[r_head];
        r_res_rd   <= r_rd[r_head];
        r_res_data <= r_data[r_head];
      end
    end
  end

  assign result_valid_o = r_res_valid;
  assign result_id_o    = r_res_id;
  assign result_we_o    = r_res_we;
  assign result_rd_o    = r_res_rd;
  assign result_data_o  = r_res_data;
`else
  assign w_pop          = w_head_kill || (w_head_res && result_ready_i);
  assign result_valid_o = w_head_res;
  assign result_id_o    = r_id[r_head];
  assign result_we_o    = r_we[r_head];
  assign result_rd_o    = r_rd[r_head];
  assign result_data_o  = r_data[r_head];
`endif

  // Allocation targets an invalid slot, so the commit scan never races with it;
  // a same-id commit in the issue cycle is folded into the new entry directly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        r_valid[i]     <= 1'b0;
        r_id[i]        <= '0;
        r_we[i]        <= 1'b0;
        r_rd[i]        <= '0;
        r_data[i]      <= '0;
        r_committed[i] <= 1'b0;
        r_killed[i]    <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < Depth; i++) begin
        if (r_valid[i] && commit_valid_i && (r_id[i] == commit_id_i)) begin
          r_committed[i] <= 1'b1;
          if (commit_kill_i) r_killed[i] <= 1'b1;
        end
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (w_alloc) begin
        r_valid[r_tail]     <= 1'b1;
        r_id[r_tail]        <= issue_id_i;
        r_we[r_tail]        <= w_wb;
        r_rd[r_tail]        <= issue_instr_i[11:7];
        r_data[r_tail]      <= w_data;
        r_committed[r_tail] <= w_same_commit;
        r_killed[r_tail]    <= w_same_commit && commit_kill_i;
        r_tail              <= r_tail + 1'b1;
      end
      unique case ({w_alloc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cvxif_copro_sequencer.sv
// Self-checking bench for cvxif_copro_sequencer: decode vector table plus ordering/kill/stall sequences.
module tb_cvxif_copro_sequencer;

`ifdef CVXIF_SEQ_RESULT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk, rst_n;
  logic        issue_valid, issue_ready, issue_accept, issue_wb;
  logic [31:0] issue_instr, rs1, rs2;
  logic [2:0]  issue_id;
  logic        commit_valid, commit_kill;
  logic [2:0]  commit_id;
  logic        result_valid, result_ready, result_we;
  logic [2:0]  result_id;
  logic [4:0]  result_rd;
  logic [31:0] result_data;

  cvxif_copro_sequencer #(.XLEN(32), .IdWidth(3), .Depth(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_instr_i(issue_instr), .issue_id_i(issue_id),
    .issue_rs1_i(rs1), .issue_rs2_i(rs2),
    .issue_accept_o(issue_accept), .issue_writeback_o(issue_wb),
    .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
    .result_valid_o(result_valid), .result_ready_i(result_ready),
    .result_id_o(result_id), .result_we_o(result_we),
    .result_rd_o(result_rd), .result_data_o(result_data)
  );

  typedef struct {
    logic [2:0]  id;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } res_t;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  id;
    logic [31:0] a, b;
    bit          acc, wb;
    logic [31:0] data;
  } vec_t;

  res_t sb[$];
  int   pop_cyc[$];
  int   cyc = 0;
  int   n_err = 0, n_chk = 0;
  vec_t vecs[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && result_valid && result_ready) begin
      res_t e;
      pop_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_result actual=id%0d required=none", result_id);
      end else begin
        e = sb.pop_front();
        chk("res.id", 64'(result_id), 64'(e.id));
        chk("res.we", 64'(result_we), 64'(e.we));
        chk("res.rd", 64'(result_rd), 64'(e.rd));
        chk("res.data", 64'(result_data), 64'(e.data));
      end
    end
  end

  task automatic do_issue(input string nm, input logic [31:0] instr, input logic [2:0] id,
                          input logic [31:0] a, input logic [31:0] b, input bit acc, input bit wb);
    issue_valid = 1'b1; issue_instr = instr; issue_id = id; rs1 = a; rs2 = b;
    @(negedge clk);
    chk({nm, ".ready"}, 64'(issue_ready), 64'd1);
    chk({nm, ".accept"}, 64'(issue_accept), 64'(acc));
    chk({nm, ".wb"}, 64'(issue_wb), 64'(wb));
    @(posedge clk); #1;
    issue_valid = 1'b0;
  endtask

  task automatic do_commit(input logic [2:0] id, input bit kill, output int c);
    commit_valid = 1'b1; commit_id = id; commit_kill = kill;
    @(negedge clk);
    c = cyc;
    @(posedge clk); #1;
    commit_valid = 1'b0; commit_kill = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 30; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    @(posedge clk); #1;
    chk({nm, ".drain"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int c, c0, c1;
    vecs[0] = '{32'h0000008B, 3'd2, 32'd5, 32'd7, 1'b1, 1'b1, 32'd12};
    vecs[1] = '{32'h000001AB, 3'd1, 32'd9, 32'd9, 1'b1, 1'b0, 32'd0};
    vecs[2] = '{32'h000002DB, 3'd3, 32'hF0F01234, 32'h0FF0FFFF, 1'b1, 1'b1, 32'hFF00EDCB};
    vecs[3] = '{32'h00000FFB, 3'd4, 32'd3, 32'd5, 1'b1, 1'b1, 32'hFFFFFFFE};
    vecs[4] = '{32'h0000010B, 3'd5, 32'hFFFFFFFF, 32'd2, 1'b1, 1'b1, 32'd1};
    vecs[5] = '{32'h000000B3, 3'd6, 32'd1, 32'd2, 1'b0, 1'b0, 32'd0};
    vecs[6] = '{32'h0000007F, 3'd7, 32'd1, 32'd2, 1'b0, 1'b0, 32'd0};
    vecs[7] = '{32'hFFFFF00B, 3'd0, 32'd10, 32'd20, 1'b1, 1'b1, 32'd30};

    rst_n = 1'b0; issue_valid = 1'b0; issue_instr = '0; issue_id = '0; rs1 = '0; rs2 = '0;
    commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0; result_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready", 64'(issue_ready), 64'd1);
    chk("rst.valid", 64'(result_valid), 64'd0);
    chk("rst.id", 64'(result_id), 64'd0);
    chk("rst.we", 64'(result_we), 64'd0);
    chk("rst.rd", 64'(result_rd), 64'd0);
    chk("rst.data", 64'(result_data), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Decode table: issue, commit, and check result latency or absence.
    for (int i = 0; i < 8; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      pop_cyc.delete();
      if (vecs[i].acc) sb.push_back('{vecs[i].id, vecs[i].wb, vecs[i].instr[11:7], vecs[i].data});
      do_issue(nm, vecs[i].instr, vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].acc, vecs[i].wb);
      do_commit(vecs[i].id, 1'b0, c);
      drain(nm);
      chk({nm, ".nres"}, 64'(pop_cyc.size()), 64'(vecs[i].acc ? 1 : 0));
      if (pop_cyc.size() != 0) chk({nm, ".lat"}, 64'(pop_cyc[0] - c), 64'(LAT));
      chk({nm, ".ready_after"}, 64'(issue_ready), 64'd1);
    end

    // Fill to Depth, then free one slot.
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{3'(i), 1'b1, 5'd1, 32'(i + 1)});
      do_issue($sformatf("full%0d", i), 32'h0000008B, 3'(i), 32'(i), 32'd1, 1'b1, 1'b1);
    end
    @(negedge clk);
    chk("full.ready_low", 64'(issue_ready), 64'd0);
    @(posedge clk); #1;
    do_commit(3'd0, 1'b0, c);
    @(negedge clk);
    chk("full.ready_popcyc", 64'(issue_ready), 64'd0);
    @(negedge clk);
    chk("full.ready_back", 64'(issue_ready), 64'd1);
    @(posedge clk); #1;
    for (int i = 1; i < 4; i++) do_commit(3'(i), 1'b0, c);
    drain("full");

    // Younger commit waits behind an uncommitted head.
    pop_cyc.delete();
    sb.push_back('{3'd0, 1'b1, 5'd7, 32'd4});
    sb.push_back('{3'd1, 1'b1, 5'd8, 32'd7});
    do_issue("ord0", 32'h0000038B, 3'd0, 32'd2, 32'd2, 1'b1, 1'b1);
    do_issue("ord1", 32'h0000047B, 3'd1, 32'd10, 32'd3, 1'b1, 1'b1);
    do_commit(3'd1, 1'b0, c1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ord.hold", 64'(result_valid), 64'd0);
    end
    @(posedge clk); #1;
    do_commit(3'd0, 1'b0, c0);
    drain("ord");
    chk("ord.nres", 64'(pop_cyc.size()), 64'd2);
    if (pop_cyc.size() == 2) begin
      chk("ord.lat", 64'(pop_cyc[0] - c0), 64'(LAT));
      chk("ord.b2b", 64'(pop_cyc[1] - pop_cyc[0]), 64'd1);
    end

    // Kill the head, commit the custom1 entry behind it.
    pop_cyc.delete();
    sb.push_back('{3'd1, 1'b0, 5'd6, 32'd0});
    do_issue("kill0", 32'h0000020B, 3'd0, 32'd1, 32'd1, 1'b1, 1'b1);
    do_issue("kill1", 32'h0000032B, 3'd1, 32'd8, 32'd8, 1'b1, 1'b0);
    do_commit(3'd0, 1'b1, c0);
    do_commit(3'd1, 1'b0, c1);
    drain("kill");
    chk("kill.nres", 64'(pop_cyc.size()), 64'd1);
    if (pop_cyc.size() == 1) chk("kill.lat", 64'(pop_cyc[0] - c1), 64'(LAT));

    // Commit arrives in the same cycle as the issue handshake.
    pop_cyc.delete();
    sb.push_back('{3'd5, 1'b1, 5'd9, 32'h55555555});
    issue_valid = 1'b1; issue_instr = 32'h000004DB; issue_id = 3'd5;
    rs1 = 32'hAAAA5555; rs2 = 32'hFFFF0000;
    commit_valid = 1'b1; commit_id = 3'd5; commit_kill = 1'b0;
    @(negedge clk);
    c = cyc;
    chk("same.accept", 64'(issue_accept), 64'd1);
    @(posedge clk); #1;
    issue_valid = 1'b0; commit_valid = 1'b0;
    drain("same");
    chk("same.nres", 64'(pop_cyc.size()), 64'd1);
    if (pop_cyc.size() == 1) chk("same.lat", 64'(pop_cyc[0] - c), 64'(LAT));

    // Stall the result channel, then reset with the result pending.
    result_ready = 1'b0;
    do_issue("stall", 32'h0000018B, 3'd3, 32'd100, 32'd23, 1'b1, 1'b1);
    do_commit(3'd3, 1'b0, c);
    for (int k = 0; k < 10; k++) begin
      if (result_valid) break;
      @(negedge clk);
    end
    chk("stall.wait", 64'(result_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall.valid", 64'(result_valid), 64'd1);
      chk("stall.id", 64'(result_id), 64'd3);
      chk("stall.data", 64'(result_data), 64'd123);
      chk("stall.rd", 64'(result_rd), 64'd3);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst2.valid", 64'(result_valid), 64'd0);
    chk("rst2.ready", 64'(issue_ready), 64'd1);
    chk("rst2.data", 64'(result_data), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    result_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst2.no_result", 64'(result_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
